// File: rtl/counter_100_pkg.sv
// Shared constants for the counter_100 display path: segment codes, digit-state
// encoding and the largest in-range count.
package counter_100_pkg;

   // Segment codes are active-high {g,f,e,d,c,b,a}; pin polarity is applied in the top.
   localparam logic [6:0] SEG_0     = 7'h3F;
   localparam logic [6:0] SEG_1     = 7'h06;
   localparam logic [6:0] SEG_2     = 7'h5B;
   localparam logic [6:0] SEG_3     = 7'h4F;
   localparam logic [6:0] SEG_4     = 7'h66;
   localparam logic [6:0] SEG_5     = 7'h6D;
   localparam logic [6:0] SEG_6     = 7'h7D;
   localparam logic [6:0] SEG_7     = 7'h07;
   localparam logic [6:0] SEG_8     = 7'h7F;
   localparam logic [6:0] SEG_9     = 7'h6F;
   localparam logic [6:0] SEG_DASH  = 7'h40;
   localparam logic [6:0] SEG_BLANK = 7'h00;

   localparam logic [0:0] ST_ONES = 1'b0;
   localparam logic [0:0] ST_TENS = 1'b1;

   localparam logic [6:0] CNT_MAX = 7'd99;

   function automatic logic [6:0] seg_code(input logic [3:0] digit);
      case (digit)
         4'd0:    seg_code = SEG_0;
         4'd1:    seg_code = SEG_1;
         4'd2:    seg_code = SEG_2;
         4'd3:    seg_code = SEG_3;
         4'd4:    seg_code = SEG_4;
         4'd5:    seg_code = SEG_5;
         4'd6:    seg_code = SEG_6;
         4'd7:    seg_code = SEG_7;
         4'd8:    seg_code = SEG_8;
         4'd9:    seg_code = SEG_9;
         default: seg_code = SEG_BLANK;
      endcase
   endfunction

endpackage

// File: rtl/counter_100_display_if.sv
// Count bus from counter_100_r into the display, plus the display pins and BCD taps.
// master = count producer / board side, slave = the display block.
interface counter_100_display_if;
   logic [6:0] i_cnt;
   logic [6:0] o_seg;
   logic [1:0] o_an;
   logic [3:0] o_tens;
   logic [3:0] o_ones;
   logic       o_ovf;

   modport master (output i_cnt, input o_seg, o_an, o_tens, o_ones, o_ovf);
   modport slave  (input i_cnt, output o_seg, o_an, o_tens, o_ones, o_ovf);
endinterface

// File: rtl/counter_100_display_bin2bcd.sv
// Binary 0..127 to two BCD digits by a compare ladder; 100..127 flag overflow
// and force both digits to 4'hF.
module bin2bcd_100
   import counter_100_pkg::*;
(
   input  logic [6:0] in,
   output logic [3:0] tens,
   output logic [3:0] ones,
   output logic       ovf
);

   logic [6:0] base;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      tens = 4'd0;
      base = 7'd0;
      for (int t = 1; t <= 9; t++) begin
         if (in >= 7'(t * 10)) begin
            tens = 4'(t);
            base = 7'(t * 10);
         end
      end
      ones = 4'(in - base);
      ovf  = (in > CNT_MAX);
      if (ovf) begin
         tens = 4'hF;
         ones = 4'hF;
      end
   end

endmodule

// File: rtl/counter_100_display.sv
// Two-digit multiplexed 7-segment driver for the counter_100_r count bus; samples
// i_cnt once per frame so the two digits always come from the same count.
module counter_100_display
   import counter_100_pkg::*;
#(
   parameter int REFRESH_DIV     = 1000,
   parameter int BLANK_LEAD_ZERO = 1,
   parameter int SEG_ACTIVE_LOW  = 1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   counter_100_display_if.slave bus
);

   localparam int               PRE_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
   localparam logic [6:0]       SEG_INV  = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
   localparam logic [1:0]       AN_INV   = (SEG_ACTIVE_LOW != 0) ? 2'b11 : 2'b00;

   logic [PRE_W-1:0] pre_cnt;
   logic             tick;
   logic [0:0]       state;
   logic [6:0]       cnt_q;

   logic [3:0]       tens;
   logic [3:0]       ones;
   logic             ovf;

   logic [6:0]       seg_nxt;
   logic [1:0]       an_nxt;

   logic [6:0]       seg_r;
   logic [1:0]       an_r;
   logic [3:0]       tens_r;
   logic [3:0]       ones_r;
   logic             ovf_r;

   assign tick = (pre_cnt == PRE_LAST);

   // Capture happens only on the TENS->ONES tick, which is what keeps a frame coherent.
   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         pre_cnt <= '0;
         state   <= ST_TENS;
         cnt_q   <= 7'd0;
      end else begin
         pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
         if (tick) begin
            if (state == ST_TENS) begin
               cnt_q <= bus.i_cnt;
               state <= ST_ONES;
            end else begin
               state <= ST_TENS;
            end
         end
      end
   end

   bin2bcd_100 u_bin2bcd (
      .in   (cnt_q),
      .tens (tens),
      .ones (ones),
      .ovf  (ovf)
   );

   always_comb begin
      an_nxt  = 2'b01;
      seg_nxt = SEG_BLANK;
      if (state == ST_ONES) begin
         an_nxt  = 2'b01;
         seg_nxt = ovf ? SEG_DASH : seg_code(ones);
      end else begin
         an_nxt = 2'b10;
         if (ovf)
            seg_nxt = SEG_DASH;
         else if ((BLANK_LEAD_ZERO != 0) && (tens == 4'd0))
            seg_nxt = SEG_BLANK;
         else
            seg_nxt = seg_code(tens);
      end
   end

   // Pin polarity is folded in before the register so the pins come straight off flops.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         seg_r  <= SEG_INV;
         an_r   <= AN_INV;
         tens_r <= 4'd0;
         ones_r <= 4'd0;
         ovf_r  <= 1'b0;
      end else begin
         seg_r  <= seg_nxt ^ SEG_INV;
         an_r   <= an_nxt ^ AN_INV;
         tens_r <= tens;
         ones_r <= ones;
         ovf_r  <= ovf;
      end
   end

   assign bus.o_seg  = seg_r;
   assign bus.o_an   = an_r;
   assign bus.o_tens = tens_r;
   assign bus.o_ones = ones_r;
   assign bus.o_ovf  = ovf_r;

endmodule

// File: tb/tb_counter_100_display.sv
// Directed bench for counter_100_display at REFRESH_DIV=4, active-low pins; a second
// instance with leading-zero blanking off shares clock, reset and i_cnt.
module tb_counter_100_display;

   logic clk;
   logic reset_n;
   int   n_tests;
   int   n_fail;

   counter_100_display_if bus ();
   counter_100_display_if bus_nb ();

   assign bus_nb.i_cnt = bus.i_cnt;

   counter_100_display #(
      .REFRESH_DIV     (4),
      .BLANK_LEAD_ZERO (1),
      .SEG_ACTIVE_LOW  (1)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   counter_100_display #(
      .REFRESH_DIV     (4),
      .BLANK_LEAD_ZERO (0),
      .SEG_ACTIVE_LOW  (1)
   ) dut_nb (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus_nb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [6:0] cnt;
      logic [3:0] tens;
      logic [3:0] ones;
      logic       ovf;
      logic [6:0] seg_ones;
      logic [6:0] seg_tens;
      logic [6:0] seg_tens_nb;
   } vec_t;

   vec_t vecs[13];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, " an"},     32'(bus.o_an),    32'h3);
      check({tag, " seg"},    32'(bus.o_seg),   32'h7F);
      check({tag, " tens"},   32'(bus.o_tens),  32'h0);
      check({tag, " ones"},   32'(bus.o_ones),  32'h0);
      check({tag, " ovf"},    32'(bus.o_ovf),   32'h0);
      check({tag, " nb seg"}, 32'(bus_nb.o_seg), 32'h7F);
   endtask

   logic [6:0] free_cnt;
   logic [6:0] captured;

   initial begin
      n_tests = 0;
      n_fail  = 0;

      vecs[0]  = '{7'd57,  4'd5, 4'd7, 1'b0, 7'h78, 7'h12, 7'h12};
      vecs[1]  = '{7'd5,   4'd0, 4'd5, 1'b0, 7'h12, 7'h7F, 7'h40};
      vecs[2]  = '{7'd100, 4'hF, 4'hF, 1'b1, 7'h3F, 7'h3F, 7'h3F};
      vecs[3]  = '{7'd127, 4'hF, 4'hF, 1'b1, 7'h3F, 7'h3F, 7'h3F};
      vecs[4]  = '{7'd99,  4'd9, 4'd9, 1'b0, 7'h10, 7'h10, 7'h10};
      vecs[5]  = '{7'd0,   4'd0, 4'd0, 1'b0, 7'h40, 7'h7F, 7'h40};
      vecs[6]  = '{7'd10,  4'd1, 4'd0, 1'b0, 7'h40, 7'h79, 7'h79};
      vecs[7]  = '{7'd83,  4'd8, 4'd3, 1'b0, 7'h30, 7'h00, 7'h00};
      vecs[8]  = '{7'd42,  4'd4, 4'd2, 1'b0, 7'h24, 7'h19, 7'h19};
      vecs[9]  = '{7'd64,  4'd6, 4'd4, 1'b0, 7'h19, 7'h02, 7'h02};
      vecs[10] = '{7'd31,  4'd3, 4'd1, 1'b0, 7'h79, 7'h30, 7'h30};
      vecs[11] = '{7'd90,  4'd9, 4'd0, 1'b0, 7'h40, 7'h10, 7'h10};
      vecs[12] = '{7'd89,  4'd8, 4'd9, 1'b0, 7'h10, 7'h00, 7'h00};

      // Reset, then the blank-tens frame of count 0 until the first capture.
      reset_n   = 1'b0;
      bus.i_cnt = 7'd0;
      step(1);
      check_reset_state("reset");
      reset_n = 1'b1;
      step(1);
      check("post-reset an",     32'(bus.o_an),     32'h1);
      check("post-reset seg",    32'(bus.o_seg),    32'h7F);
      check("post-reset nb seg", 32'(bus_nb.o_seg), 32'h40);
      step(3);
      check("first capture an", 32'(bus.o_an), 32'h1);

      // At each loop start we sit just after a capture edge.
      for (int i = 0; i < 13; i++) begin
         bus.i_cnt = vecs[i].cnt;
         step(8);
         check($sformatf("v%0d boundary an", i), 32'(bus.o_an), 32'h1);
         step(1);
         check($sformatf("v%0d ones an", i),   32'(bus.o_an),     32'h2);
         check($sformatf("v%0d ones seg", i),  32'(bus.o_seg),    32'(vecs[i].seg_ones));
         check($sformatf("v%0d tens", i),      32'(bus.o_tens),   32'(vecs[i].tens));
         check($sformatf("v%0d ones", i),      32'(bus.o_ones),   32'(vecs[i].ones));
         check($sformatf("v%0d ovf", i),       32'(bus.o_ovf),    32'(vecs[i].ovf));
         step(3);
         check($sformatf("v%0d ones hold an", i), 32'(bus.o_an), 32'h2);
         step(1);
         check($sformatf("v%0d tens an", i),     32'(bus.o_an),     32'h1);
         check($sformatf("v%0d tens seg", i),    32'(bus.o_seg),    32'(vecs[i].seg_tens));
         check($sformatf("v%0d nb tens seg", i), 32'(bus_nb.o_seg), 32'(vecs[i].seg_tens_nb));
         step(3);
      end

      // Mid-frame change 42 -> 99: the whole 42 frame stays intact.
      bus.i_cnt = 7'd42;
      step(8);
      step(1);
      bus.i_cnt = 7'd99;
      for (int c = 0; c < 8; c++) begin
         check($sformatf("midframe c%0d tens", c), 32'(bus.o_tens), 32'd4);
         check($sformatf("midframe c%0d ones", c), 32'(bus.o_ones), 32'd2);
         if (c == 4)
            check("midframe tens seg", 32'(bus.o_seg), 32'h19);
         step(1);
      end
      check("midframe new tens", 32'(bus.o_tens), 32'd9);
      check("midframe new ones", 32'(bus.o_ones), 32'd9);
      check("midframe new seg",  32'(bus.o_seg),  32'h10);
      step(7);

      // Reset while TENS of 99 is showing; prescaler restarts from 0.
      step(8);
      step(5);
      check("pre-reset tens an",  32'(bus.o_an),  32'h1);
      check("pre-reset tens seg", 32'(bus.o_seg), 32'h10);
      reset_n = 1'b0;
      step(1);
      check_reset_state("midreset");
      reset_n   = 1'b1;
      bus.i_cnt = 7'd57;
      step(1);
      check("rel+1 an",   32'(bus.o_an),   32'h1);
      check("rel+1 seg",  32'(bus.o_seg),  32'h7F);
      check("rel+1 tens", 32'(bus.o_tens), 32'h0);
      step(3);
      check("rel+4 an", 32'(bus.o_an), 32'h1);
      step(1);
      check("rel+5 an",   32'(bus.o_an),   32'h2);
      check("rel+5 seg",  32'(bus.o_seg),  32'h78);
      check("rel+5 tens", 32'(bus.o_tens), 32'd5);
      check("rel+5 ones", 32'(bus.o_ones), 32'd7);
      step(7);

      // Free-running source, +1 per cycle with 99->0 wrap; samples pass 99 then 7.
      free_cnt = 7'd4;
      captured = 7'd0;
      for (int f = 0; f < 20; f++) begin
         for (int c = 0; c < 8; c++) begin
            if (c == 1 && f > 0) begin
               check($sformatf("freerun f%0d value", f),
                     32'(bus.o_tens) * 10 + 32'(bus.o_ones), 32'(captured));
               check($sformatf("freerun f%0d ovf", f), 32'(bus.o_ovf), 32'h0);
            end
            bus.i_cnt = free_cnt;
            if (c == 7)
               captured = free_cnt;
            step(1);
            free_cnt = (free_cnt == 7'd99) ? 7'd0 : free_cnt + 7'd1;
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
